bp_fe_queue_ckpt: RTL and testbench

BP_FE_QUEUE_CKPT -- requirements
Module: bp_fe_queue_ckpt

---
 rtl/bp_common_pkg.sv | 37 +++
 rtl/bsg_mem_1r1w.sv | 39 +++
 rtl/bp_fe_queue_ckpt.sv | 111 +++++++++++
 tb/tb_bp_fe_queue_ckpt.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/bp_common_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bp_common_pkg
//  Description : Shared FE/BE interface types. Holds the processor config
//                selector, the fe_queue entry struct and the helper that
//                turns a config into an fe_queue entry width.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package bp_common_pkg;

   typedef enum logic [1:0] {
      e_bp_inv_cfg     = 2'd0,
      e_bp_unicore_cfg = 2'd1
   } bp_params_e;

   typedef enum logic [1:0] {
      e_fe_fetch     = 2'd0,
      e_fe_exception = 2'd1
   } bp_fe_queue_type_e;

   typedef struct packed {
      bp_fe_queue_type_e msg_type;
      logic [38:0]       pc;
      logic [31:0]       instr;
   } bp_fe_queue_s;

   // Every config currently shares the same FE/BE message layout.
   function automatic int fe_queue_width(input bp_params_e cfg);
      case (cfg)
         e_bp_unicore_cfg: return $bits(bp_fe_queue_s);
         default:          return $bits(bp_fe_queue_s);
      endcase
   endfunction

endpackage
`default_nettype wire

// File: rtl/bsg_mem_1r1w.sv
`default_nettype none
// ============================================================================
//  Module      : bsg_mem_1r1w
//  Description : One-write, one-read register-file memory with a synchronous
//                write port and an asynchronous (combinational) read port.
//                Contents are not reset.
//  Ports       : clk_i     - write clock
//                w_v_i     - write enable
//                w_addr_i  - write address
//                w_data_i  - write data
//                r_addr_i  - read address
//                r_data_o  - read data (combinational)
//  Revision    : 1.0 - initial release
// ============================================================================
module bsg_mem_1r1w #(
   parameter int width_p = 8,
   parameter int els_p   = 4,
   localparam int addr_width_lp = (els_p > 1) ? $clog2(els_p) : 1
) (
   input  logic                     clk_i,
   input  logic                     w_v_i,
   input  logic [addr_width_lp-1:0] w_addr_i,
   input  logic [width_p-1:0]       w_data_i,
   input  logic [addr_width_lp-1:0] r_addr_i,
   output logic [width_p-1:0]       r_data_o
);

   logic [width_p-1:0] mem_q [els_p];

   always_ff @(posedge clk_i) begin
      if (w_v_i) begin
         mem_q[w_addr_i] <= w_data_i;
      end
   end

   assign r_data_o = mem_q[r_addr_i];

endmodule
`default_nettype wire

// File: rtl/bp_fe_queue_ckpt.sv
`default_nettype none
// ============================================================================
//  Module      : bp_fe_queue_ckpt
//  Description : FE->BE queue with a checkpointed (commit) read pointer.
//                Entries are issued speculatively through rptr, retired
//                through cptr, and the BE may roll rptr back to cptr or
//                flush the whole queue.
//  Ports       : clk_i            - clock
//                reset_n_i        - asynchronous active-low reset
//                fe_queue_i       - entry from the FE
//                fe_queue_v_i     - FE entry valid
//                fe_queue_ready_o - queue can accept an entry
//                fe_queue_o       - entry at the speculative read pointer
//                fe_queue_v_o     - fe_queue_o valid
//                fe_queue_yumi_i  - BE consumed fe_queue_o
//                fe_queue_deq_i   - BE committed the oldest issued entry
//                fe_queue_roll_i  - BE rolls back to the commit point
//                fe_queue_clr_i   - BE flushes the queue
//  Revision    : 1.0 - initial release
// ============================================================================
module bp_fe_queue_ckpt
   import bp_common_pkg::*;
#(
   parameter bp_params_e bp_params_p = e_bp_inv_cfg,
   parameter int         els_p       = 8,
   localparam int fe_queue_width_lp  = fe_queue_width(bp_params_p)
) (
   input  logic                         clk_i,
   input  logic                         reset_n_i,
   input  logic [fe_queue_width_lp-1:0] fe_queue_i,
   input  logic                         fe_queue_v_i,
   output logic                         fe_queue_ready_o,
   output logic [fe_queue_width_lp-1:0] fe_queue_o,
   output logic                         fe_queue_v_o,
   input  logic                         fe_queue_yumi_i,
   input  logic                         fe_queue_deq_i,
   input  logic                         fe_queue_roll_i,
   input  logic                         fe_queue_clr_i
);

   localparam int lg_els_lp = $clog2(els_p);
   localparam int ptr_w_lp  = lg_els_lp + 1;
   localparam logic [ptr_w_lp-1:0] one_lp = ptr_w_lp'(1);
   localparam logic [ptr_w_lp-1:0] els_lp = ptr_w_lp'(els_p);

   // Pointers carry an extra wrap bit so full (distance == els_p) and
   // empty (distance == 0) are distinguishable.
   logic [ptr_w_lp-1:0] wptr_q, wptr_d;
   logic [ptr_w_lp-1:0] rptr_q, rptr_d;
   logic [ptr_w_lp-1:0] cptr_q, cptr_d;
   logic [ptr_w_lp-1:0] used;
   logic                enq;

   // Occupancy is measured against the commit pointer: issued but not yet
   // committed entries must survive for a possible rollback.
   assign used             = wptr_q - cptr_q;
   assign fe_queue_ready_o = (used < els_lp);
   assign fe_queue_v_o     = (rptr_q != wptr_q);

   assign enq = fe_queue_v_i & fe_queue_ready_o & ~fe_queue_clr_i & ~fe_queue_roll_i;

   always_comb begin
      cptr_d = fe_queue_deq_i ? (cptr_q + one_lp) : cptr_q;
      rptr_d = rptr_q;
      wptr_d = wptr_q;
      if (fe_queue_clr_i) begin
         // Flush everything past the (post-deq) commit point.
         rptr_d = cptr_d;
         wptr_d = cptr_d;
      end else if (fe_queue_roll_i) begin
         // Replay from the (post-deq) commit point; new entries are dropped.
         rptr_d = cptr_d;
      end else begin
         if (fe_queue_yumi_i) rptr_d = rptr_q + one_lp;
         if (enq)             wptr_d = wptr_q + one_lp;
      end
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         wptr_q <= '0;
         rptr_q <= '0;
         cptr_q <= '0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
         cptr_q <= cptr_d;
      end
   end

   bsg_mem_1r1w #(
      .width_p (fe_queue_width_lp),
      .els_p   (els_p)
   ) mem (
      .clk_i    (clk_i),
      .w_v_i    (enq),
      .w_addr_i (wptr_q[lg_els_lp-1:0]),
      .w_data_i (fe_queue_i),
      .r_addr_i (rptr_q[lg_els_lp-1:0]),
      .r_data_o (fe_queue_o)
   );

`ifndef SYNTHESIS
   a_yumi_needs_valid : assert property (@(posedge clk_i) disable iff (!reset_n_i)
      !(fe_queue_yumi_i && !fe_queue_v_o));
   a_deq_needs_issued : assert property (@(posedge clk_i) disable iff (!reset_n_i)
      !(fe_queue_deq_i && (cptr_q == rptr_q)));
`endif

endmodule
`default_nettype wire

// File: tb/tb_bp_fe_queue_ckpt.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bp_fe_queue_ckpt
//  Description : Directed, table-driven bench for bp_fe_queue_ckpt with a
//                depth of four entries.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bp_fe_queue_ckpt;
   import bp_common_pkg::*;

   localparam int W = fe_queue_width(e_bp_inv_cfg);

   logic         clk_i = 1'b0;
   logic         reset_n_i;
   logic [W-1:0] fe_queue_i;
   logic         fe_queue_v_i;
   logic         fe_queue_ready_o;
   logic [W-1:0] fe_queue_o;
   logic         fe_queue_v_o;
   logic         fe_queue_yumi_i;
   logic         fe_queue_deq_i;
   logic         fe_queue_roll_i;
   logic         fe_queue_clr_i;

   int n_cmp = 0;
   int n_err = 0;

   bp_fe_queue_ckpt #(
      .bp_params_p (e_bp_inv_cfg),
      .els_p       (4)
   ) dut (
      .clk_i            (clk_i),
      .reset_n_i        (reset_n_i),
      .fe_queue_i       (fe_queue_i),
      .fe_queue_v_i     (fe_queue_v_i),
      .fe_queue_ready_o (fe_queue_ready_o),
      .fe_queue_o       (fe_queue_o),
      .fe_queue_v_o     (fe_queue_v_o),
      .fe_queue_yumi_i  (fe_queue_yumi_i),
      .fe_queue_deq_i   (fe_queue_deq_i),
      .fe_queue_roll_i  (fe_queue_roll_i),
      .fe_queue_clr_i   (fe_queue_clr_i)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic       v;
      logic [7:0] tag;
      logic       yumi;
      logic       deq;
      logic       roll;
      logic       clr;
      logic       e_ready;
      logic       e_v;
      logic [7:0] e_tag;
   } vec_t;

   vec_t vecs[$];

   // Spread an 8-bit tag over the whole entry so every bit position varies.
   function automatic logic [W-1:0] mk(input logic [7:0] t);
      logic [W-1:0] d;
      for (int i = 0; i < W; i++) d[i] = t[i % 8] ^ (((i / 8) % 2) == 1);
      return d;
   endfunction

   task automatic add(input logic v, input logic [7:0] tag,
                      input logic yumi, input logic deq, input logic roll, input logic clr,
                      input logic e_ready, input logic e_v, input logic [7:0] e_tag);
      vec_t x;
      x.v = v; x.tag = tag; x.yumi = yumi; x.deq = deq; x.roll = roll; x.clr = clr;
      x.e_ready = e_ready; x.e_v = e_v; x.e_tag = e_tag;
      vecs.push_back(x);
   endtask

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Drive one cycle of inputs, clock it, then check the resulting outputs.
   task automatic step(input string name, input vec_t x);
      @(negedge clk_i);
      fe_queue_v_i    = x.v;
      fe_queue_i      = mk(x.tag);
      fe_queue_yumi_i = x.yumi;
      fe_queue_deq_i  = x.deq;
      fe_queue_roll_i = x.roll;
      fe_queue_clr_i  = x.clr;
      @(posedge clk_i);
      #1;
      chk({name, " ready"}, W'(fe_queue_ready_o), W'(x.e_ready));
      chk({name, " v_o"},   W'(fe_queue_v_o),     W'(x.e_v));
      if (x.e_v) chk({name, " data"}, fe_queue_o, mk(x.e_tag));
   endtask

   function automatic vec_t mkv(input logic v, input logic [7:0] tag,
                                input logic yumi, input logic deq, input logic roll, input logic clr,
                                input logic e_ready, input logic e_v, input logic [7:0] e_tag);
      vec_t x;
      x.v = v; x.tag = tag; x.yumi = yumi; x.deq = deq; x.roll = roll; x.clr = clr;
      x.e_ready = e_ready; x.e_v = e_v; x.e_tag = e_tag;
      return x;
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset_n_i = 1'b0;
      fe_queue_v_i = 1'b0; fe_queue_i = '0; fe_queue_yumi_i = 1'b0;
      fe_queue_deq_i = 1'b0; fe_queue_roll_i = 1'b0; fe_queue_clr_i = 1'b0;

      // Fill/full, then drain and commit.
      add(1,'h0A,0,0,0,0, 1,1,'h0A);
      add(1,'h0B,0,0,0,0, 1,1,'h0A);
      add(1,'h0C,0,0,0,0, 1,1,'h0A);
      add(1,'h0D,0,0,0,0, 0,1,'h0A);
      add(1,'h0E,0,0,0,0, 0,1,'h0A);
      add(0,'h00,1,0,0,0, 0,1,'h0B);
      add(0,'h00,1,0,0,0, 0,1,'h0C);
      add(0,'h00,1,0,0,0, 0,1,'h0D);
      add(0,'h00,1,0,0,0, 0,0,'h00);
      for (int i = 0; i < 4; i++) add(0,'h00,0,1,0,0, 1,0,'h00);
      // Rollback.
      add(1,'h1A,0,0,0,0, 1,1,'h1A);
      add(1,'h1B,0,0,0,0, 1,1,'h1A);
      add(1,'h1C,0,0,0,0, 1,1,'h1A);
      add(0,'h00,1,0,0,0, 1,1,'h1B);
      add(0,'h00,1,0,0,0, 1,1,'h1C);
      add(0,'h00,0,1,0,0, 1,1,'h1C);
      add(0,'h00,0,0,1,0, 1,1,'h1B);
      add(0,'h00,1,0,0,0, 1,1,'h1C);
      add(0,'h00,1,0,0,0, 1,0,'h00);
      add(0,'h00,0,1,0,0, 1,0,'h00);
      add(0,'h00,0,1,0,0, 1,0,'h00);
      // Clear with a simultaneous (dropped) enqueue.
      add(1,'h2A,0,0,0,0, 1,1,'h2A);
      add(1,'h2B,0,0,0,0, 1,1,'h2A);
      add(1,'h2C,0,0,0,0, 1,1,'h2A);
      add(0,'h00,1,0,0,0, 1,1,'h2B);
      add(1,'h2D,0,0,0,1, 1,0,'h00);
      add(1,'h2E,0,0,0,0, 1,1,'h2E);
      add(0,'h00,1,0,0,0, 1,0,'h00);
      add(0,'h00,0,1,0,0, 1,0,'h00);
      // Streaming across pointer wrap; second row is enqueue+yumi on one entry.
      add(1,'h30,0,0,0,0, 1,1,'h30);
      add(1,'h31,1,0,0,0, 1,1,'h31);
      for (int k = 2; k < 10; k++) add(1, 8'(8'h30 + k), 1,1,0,0, 1,1, 8'(8'h30 + k));
      add(0,'h00,1,1,0,0, 1,0,'h00);
      add(0,'h00,0,1,0,0, 1,0,'h00);
      // Same-cycle deq+roll.
      add(1,'h4B,0,0,0,0, 1,1,'h4B);
      add(1,'h4C,0,0,0,0, 1,1,'h4B);
      add(0,'h00,1,0,0,0, 1,1,'h4C);
      add(0,'h00,1,0,0,0, 1,0,'h00);
      add(0,'h00,0,1,1,0, 1,1,'h4C);
      add(0,'h00,1,0,0,0, 1,0,'h00);
      add(0,'h00,0,1,0,0, 1,0,'h00);

      // Reset state.
      repeat (2) @(negedge clk_i);
      #1;
      chk("reset v_o",   W'(fe_queue_v_o),     W'(1'b0));
      chk("reset ready", W'(fe_queue_ready_o), W'(1'b1));
      @(negedge clk_i);
      reset_n_i = 1'b1;

      foreach (vecs[i]) step($sformatf("vec%0d", i), vecs[i]);

      // Asynchronous reset mid-stream discards queued entries.
      step("rst q0", mkv(1,'h60,0,0,0,0, 1,1,'h60));
      step("rst q1", mkv(1,'h61,0,0,0,0, 1,1,'h60));
      step("rst q2", mkv(1,'h62,0,0,0,0, 1,1,'h60));
      fe_queue_v_i = 1'b0;
      #2;
      reset_n_i = 1'b0;
      #1;
      chk("rst async v_o",   W'(fe_queue_v_o),     W'(1'b0));
      chk("rst async ready", W'(fe_queue_ready_o), W'(1'b1));
      @(negedge clk_i);
      reset_n_i = 1'b1;
      step("rst X",    mkv(1,'h77,0,0,0,0, 1,1,'h77));
      step("rst yumi", mkv(0,'h00,1,0,0,0, 1,0,'h00));
      step("rst deq",  mkv(0,'h00,0,1,0,0, 1,0,'h00));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
